twenty_bit_div_sequencer: RTL and testbench

TWENTY_BIT_DIV_SEQUENCER -- requirements
Module: twenty_bit_div_sequencer

---
 rtl/twenty_bit_div_sequencer_if.sv | 22 ++
 rtl/twenty_bit_div_sequencer.sv | 128 ++++++++++++
 tb/tb_twenty_bit_div_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/twenty_bit_div_sequencer_if.sv
// Handshake and result bus for the 20-bit sequential divider.
// The requester side is the master. The divider is the slave.
interface twenty_bit_div_sequencer_if;
  logic        start;
  logic [19:0] dividend;
  logic [19:0] divisor;
  logic        busy;
  logic        done;
  logic [19:0] quotient;
  logic [19:0] remainder;
  logic        div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/twenty_bit_div_sequencer.sv
// 20-bit unsigned restoring divider, one iteration per clock.
// Uses a single shared subtractor. The FSM is IDLE -> CALC (20 edges) -> DONE -> IDLE.
// A zero divisor skips CALC and reports quotient all-ones and remainder = dividend.

// Borrow-out subtractor: d = i0 - i1 (mod 2^20), bout = (i0 < i1).
module twenty_bit_subtractor (
  input  logic [19:0] i0,
  input  logic [19:0] i1,
  output logic [19:0] d,
  output logic        bout
);
  logic [20:0] diff;

  // The extra top bit of the 21-bit difference is the borrow.
  assign diff = {1'b0, i0} - {1'b0, i1};
  assign d    = diff[19:0];
  assign bout = diff[20];
endmodule

module twenty_bit_div_sequencer (
  input  logic                          clk,
  input  logic                          rst_n,
  twenty_bit_div_sequencer_if.slave     bus
);
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [4:0]  LAST_ITER = 5'd19;
  localparam logic [19:0] ALL_ONES  = 20'hFFFFF;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [19:0] q_q;      // quotient / dividend shift register
  logic [19:0] r_q;      // partial remainder
  logic [19:0] d_q;      // latched divisor
  logic        busy_q;
  logic        done_q;
  logic        dbz_q;

  logic [19:0] sub_i0;
  logic [19:0] sub_d;
  logic        sub_bout;
  logic        accept;
  logic [19:0] r_d;
  logic [19:0] q_d;

  // Shift the next dividend bit into the remainder, then trial-subtract D.
  assign sub_i0 = {r_q[18:0], q_q[19]};

  twenty_bit_subtractor u_sub (
    .i0   (sub_i0),
    .i1   (d_q),
    .d    (sub_d),
    .bout (sub_bout)
  );

  // If R[19] is set, the true shifted value has 21 bits and always exceeds D.
  // The wrapped 20-bit difference is then still the exact remainder.
  assign accept = r_q[19] | ~sub_bout;
  assign r_d    = accept ? sub_d : sub_i0;
  assign q_d    = {q_q[18:0], accept};

  // Control FSM with datapath registers and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            busy_q <= 1'b1;
            if (bus.divisor == '0) begin
              q_q     <= ALL_ONES;
              r_q     <= bus.dividend;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              d_q     <= bus.divisor;
              q_q     <= bus.dividend;
              r_q     <= '0;
              cnt_q   <= '0;
              dbz_q   <= 1'b0;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == LAST_ITER) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          // One-cycle result strobe. Any start seen here is dropped.
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = q_q;
  assign bus.remainder   = r_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_twenty_bit_div_sequencer.sv
// Randomized self-checking bench for twenty_bit_div_sequencer.
// The reference is plain integer '/' and '%', with the zero-divisor rule.
module tb_twenty_bit_div_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  twenty_bit_div_sequencer_if bus();

  twenty_bit_div_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [19:0] a, input logic [19:0] b,
                                output logic [19:0] q, output logic [19:0] r,
                                output logic z);
    if (b == 20'd0) begin
      q = 20'hFFFFF; r = a; z = 1'b1;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endfunction

  // Present operands for one sampling edge, then scramble them while busy.
  task automatic launch(input logic [19:0] a, input logic [19:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.dividend = 20'($urandom);
    bus.divisor  = 20'($urandom);
  endtask

  // Returns the edge count, where the sampling edge counts as edge 1.
  task automatic wait_done(output int n);
    n = 1;
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic div_check(input string tag, input logic [19:0] a, input logic [19:0] b);
    logic [19:0] eq, er;
    logic        ez;
    int          n;
    model(a, b, eq, er, ez);
    launch(a, b);
    wait_done(n);
    chk({tag, ".lat"}, n, (b == 20'd0) ? 1 : 21);
    chk({tag, ".q"}, bus.quotient, eq);
    chk({tag, ".r"}, bus.remainder, er);
    chk({tag, ".dbz"}, bus.div_by_zero, ez);
    chk({tag, ".busy"}, bus.busy, 1'b1);
    @(negedge clk);
    chk({tag, ".pulse"}, bus.done, 1'b0);
    chk({tag, ".idle"}, bus.busy, 1'b0);
    chk({tag, ".hold"}, bus.quotient, eq);
  endtask

  initial begin
    int n, ndone;
    logic [19:0] a, b;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;

    // Reset state
    #1;
    chk("rst.busy", bus.busy, 1'b0);
    chk("rst.done", bus.done, 1'b0);
    chk("rst.q", bus.quotient, 20'd0);
    chk("rst.r", bus.remainder, 20'd0);
    chk("rst.dbz", bus.div_by_zero, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    div_check("basic", 20'd100, 20'd7);
    div_check("max_by1", 20'hFFFFF, 20'd1);
    div_check("zero_by5", 20'd0, 20'd5);
    div_check("5_bymax", 20'd5, 20'hFFFFF);
    div_check("r19a", 20'hFFFFF, 20'hFFFFE);
    div_check("r19b", 20'hC0000, 20'h80001);
    div_check("dz", 20'h01234, 20'd0);
    div_check("dz_clear", 20'd100, 20'd7);

    // A start re-pulse mid-CALC is ignored: no queued second result.
    launch(20'd1000, 20'd3);
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.dividend = 20'd77; bus.divisor = 20'd2;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n);
    chk("repulse.q", bus.quotient, 20'd333);
    chk("repulse.r", bus.remainder, 20'd1);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    chk("repulse.nodone", ndone, 0);
    chk("repulse.hold", bus.quotient, 20'd333);

    // Holding start high gives back-to-back results 22 cycles apart.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 20'd50000; bus.divisor = 20'd123;
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("held.q1", bus.quotient, 20'd50000 / 20'd123);
    @(negedge clk);
    n = 1;
    while (bus.done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("held.gap", n, 22);
    chk("held.r2", bus.remainder, 20'd50000 % 20'd123);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("held.stop", bus.busy, 1'b0);

    // Reset at iteration 12 aborts the division without any done pulse.
    launch(20'd300, 20'd7);
    repeat (11) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort.busy", bus.busy, 1'b0);
    chk("abort.q", bus.quotient, 20'd0);
    chk("abort.r", bus.remainder, 20'd0);
    ndone = 0;
    repeat (3) begin @(negedge clk); if (bus.done === 1'b1) ndone++; end
    rst_n = 1'b1;
    repeat (30) begin @(negedge clk); if (bus.done === 1'b1) ndone++; end
    chk("abort.nodone", ndone, 0);
    div_check("after_rst", 20'd100, 20'd7);

    // Reset during DONE clears the zero-divisor flag and the pulse.
    launch(20'd9, 20'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_done.done", bus.done, 1'b0);
    chk("rst_done.dbz", bus.div_by_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized operands with a mix of divisor shapes
    for (int i = 0; i < 40; i++) begin
      a = 20'($urandom);
      case ($urandom_range(0, 4))
        0: b = 20'd0;
        1: b = 20'($urandom_range(1, 15));
        2: b = 20'($urandom);
        3: b = a;
        default: b = 20'($urandom_range(20'h80000, 20'hFFFFF));
      endcase
      div_check($sformatf("rnd%0d", i), a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
